// File: rtl/result_fifo.sv
// Result FIFO behind the constant-divider stage: captures every valid divider
// result, releases it on RD_EN, and flags (never hides) overflow.
module result_fifo #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          R_IN,
  input  logic [N-1:0]  D_IN,
  input  logic          RD_EN,
  output logic [N-1:0]  D_OUT,
  output logic          R_OUT,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF
);

  logic [N-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          rout_q, rout_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  assign FULL  = (count_q == (AW+1)'(DEPTH));
  assign EMPTY = (count_q == '0);

  // A full FIFO still accepts a push when the same cycle frees an entry.
  assign pop  = EN & RD_EN & ~EMPTY;
  assign push = EN & R_IN & (~FULL | pop);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dout_d  = dout_q;
    rout_d  = 1'b0;
    ovf_d   = ovf_q;
    if (push) begin
      wp_d = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d   = rp_q + AW'(1);
      dout_d = mem_q[rp_q];
      rout_d = 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
    if (EN && R_IN && FULL && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      rout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      rout_q  <= rout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem_q[wp_q] <= D_IN;
    end
  end

  assign D_OUT = dout_q;
  assign R_OUT = rout_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: doc/result_fifo.md
# result_fifo

Synchronous FIFO that sits directly downstream of the constant-divider stage. It captures every valid result (`R_IN` high) from the divider's `R_OUT`/`D_OUT` pair and holds it until a consumer pops it with `RD_EN`. The stage lets a host or slower consumer drain pipeline results without stalling the divider. The divider has no backpressure, so overflow is detected and flagged, never hidden.

## Interface
Parameters:
- `N`, default 16: data width, matching the divider's `N`.
- `DEPTH`, default 8: number of entries. Must be a power of two, at least 2.
- `AW`, default 3: pointer width. Must equal log2(`DEPTH`).

Ports:
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RST`  in  1: reset. Synchronous, active-high.
- `EN`  in  1: stage enable. When low, no push, no pop, and state holds.
- `R_IN`  in  1: valid strobe from the upstream divider's `R_OUT`.
- `D_IN`  in  N: data from the upstream divider's `D_OUT`.
- `RD_EN`  in  1: pop request from the consumer.
- `D_OUT`  out  N: registered popped word.
- `R_OUT`  out  1: high for exactly one cycle per popped word.
- `FULL`  out  1: asserted when `COUNT == DEPTH`.
- `EMPTY`  out  1: asserted when `COUNT == 0`.
- `COUNT`  out  AW+1: current occupancy, 0 to `DEPTH`.
- `OVF`  out  1: sticky overflow flag.

## Operation
Storage and pointers:
- Storage is a `DEPTH`×`N` register array.
- Write pointer `wp` and read pointer `rp` are each `AW` bits and wrap modulo `DEPTH`.
- `COUNT` is a separate registered counter.

Push and pop:
- push = `EN & R_IN & (!FULL | pop)`.
- pop = `EN & RD_EN & !EMPTY`.
- On push: `mem[wp] <= D_IN` and `wp <= wp+1`.
- On pop: `D_OUT <= mem[rp]`, `rp <= rp+1`, and `R_OUT <= 1`. Otherwise `R_OUT <= 0` and `D_OUT` holds.

Occupancy:
- `COUNT` increments on push only, decrements on pop only, and is unchanged on both or neither.

Simultaneous events:
- Full with push and pop in the same cycle: both are accepted and `COUNT` stays at `DEPTH`.
- Empty with push and pop in the same cycle: pop is ignored (no bypass) and push is accepted, so `COUNT` becomes 1 and `R_OUT` is 0.

Overflow:
- Overflow occurs when `EN & R_IN & FULL & !pop`. The incoming word is dropped, storage and pointers are unchanged, and `OVF <= 1`.
- `OVF` is cleared only by `RST`.

Enable:
- `EN` low: no push, no pop, no overflow detection, and `R_OUT <= 0`.
- `D_IN`/`R_IN` arriving while `EN` is low are ignored. This matches the divider, which also freezes on `EN` low.

Flags:
- `FULL` and `EMPTY` are derived combinationally from the registered `COUNT`.

Reset (`RST` high at an edge):
- `wp`, `rp`, and `COUNT` go to 0.
- `D_OUT`, `R_OUT`, and `OVF` go to 0.
- After reset, `EMPTY`=1 and `FULL`=0.
- Memory contents are don't-care.
- Reset mid-operation discards all stored words. A push or pop requested in the same cycle as `RST` is ignored.

## Timing
- Push at edge t makes the word poppable from edge t+1: `EMPTY` falls and `COUNT` updates after edge t.
- Pop latency: `RD_EN` sampled at edge t gives `D_OUT`/`R_OUT` valid in the cycle following edge t.
- Minimum latency from `R_IN` to `R_OUT` is 2 edges.
- Throughput is one push and one pop per cycle, sustained at any occupancy.
- `COUNT`, `FULL`, and `EMPTY` reflect state after the most recent edge. They never anticipate same-cycle requests.
- Pointer wrap from `DEPTH`-1 to 0 costs no extra cycle.

## Test plan
- **Reset values:** assert `RST` for 2 cycles, then release. Required: `COUNT`=0, `EMPTY`=1, `FULL`=0, `R_OUT`=0, `D_OUT`=0, `OVF`=0.
- **Order and latency:** push 0x0003, 0x0005, 0x0007 on consecutive cycles, then hold `RD_EN`=1 for 4 cycles. Required: `R_OUT` pulses for 3 cycles with `D_OUT` = 3, 5, 7 in that order. The 4th request produces `R_OUT`=0 and `EMPTY`=1.
- **Fill and overflow:** push 9 words, 1 to 9, with `DEPTH`=8 and no pops. Required:
  - `FULL`=1 after the 8th push.
  - `OVF`=1 after the 9th push.
  - Draining returns 1 to 8; word 9 is absent.
  - `OVF` stays 1 until `RST`.
- **Simultaneous events at boundaries:**
  - At `FULL`, push 0xAAAA while popping. Required: `COUNT` stays 8, `OVF` stays 0, and 0xAAAA is the last word drained.
  - At `EMPTY`, push and pop together. Required: `R_OUT`=0 and `COUNT`=1.
- **Wrap and enable:** run 20 push/pop pairs so the pointers wrap twice. Required: data order is intact.
  - Then drop `EN` for 3 cycles while `R_IN`=1 and `RD_EN`=1. Required: `COUNT` is unchanged and `R_OUT`=0.
- **Reset mid-stream:** with 5 words stored, pulse `RST` concurrent with `RD_EN`. Required: `COUNT`=0, `R_OUT`=0, and `EMPTY`=1 on the next cycle.
